// File: rtl/ul4_pkg.sv
// Shared constants, FSM encoding and golden model for the ul4 self-test.
package ul4_pkg;

   localparam int unsigned VEC_W    = 10;
   localparam int unsigned IDX_LAST = 1023;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   // Expected ul4 Out for a given operand pair and op select
   function automatic logic [3:0] ul4_golden(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [1:0] s);
      logic [3:0] r;
      r = '0;
      case (s)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOT:  r = ~a;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ul4_autotest_if.sv
// Handshake, status and ul4-facing signals of the self-test sequencer.
interface ul4_autotest_if #(
   parameter int unsigned ERR_W = 10
);
   logic                       start;
   logic [3:0]                 ul_out;
   logic [3:0]                 a_o;
   logic [3:0]                 b_o;
   logic [1:0]                 s_o;
   logic                       busy;
   logic                       done;
   logic                       pass;
   logic [ERR_W-1:0]           err_count;
   logic                       fail_seen;
   logic [ul4_pkg::VEC_W-1:0]  fail_idx;

   modport master (
      output start, ul_out,
      input  a_o, b_o, s_o, busy, done, pass, err_count, fail_seen, fail_idx
   );

   modport slave (
      input  start, ul_out,
      output a_o, b_o, s_o, busy, done, pass, err_count, fail_seen, fail_idx
   );
endinterface

// File: rtl/ul4_vecgen.sv
// Test-vector index counter; the index bits map directly onto a, b and s.
module ul4_vecgen
   import ul4_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [3:0]       a,
   output logic [3:0]       b,
   output logic [1:0]       s,
   output logic [VEC_W-1:0] idx,
   output logic             last_vec
);

   logic [VEC_W-1:0] idx_q;

   // Index register: cleared on a new run, advanced after each compare
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
      end else if (clr) begin
         idx_q <= '0;
      end else if (inc) begin
         idx_q <= idx_q + VEC_W'(1);
      end
   end

   assign a        = idx_q[3:0];
   assign b        = idx_q[7:4];
   assign s        = idx_q[9:8];
   assign idx      = idx_q;
   assign last_vec = (idx_q == VEC_W'(IDX_LAST));

endmodule

// File: rtl/ul4_autotest.sv
// Self-test sequencer: sweeps all ul4 vectors, compares against the golden
// model and reports a pass/fail verdict with a start/done handshake.
module ul4_autotest
   import ul4_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 1,
   parameter int unsigned ERR_W      = 10
) (
   input  logic          clk,
   input  logic          reset,
   ul4_autotest_if.slave bus
);

   localparam int unsigned       CNT_W       = 4;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       vec_a;
   logic [3:0]       vec_b;
   logic [1:0]       vec_s;
   logic [VEC_W-1:0] vec_idx;
   logic             last_vec;
   logic             vec_clr_c;
   logic             vec_inc_c;
   logic             cnt_load_c;
   logic             check_c;
   logic             mismatch_c;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             fail_seen_q;
   logic [ERR_W-1:0] err_q;
   logic [VEC_W-1:0] fail_idx_q;

   ul4_vecgen u_vecgen (
      .clk      (clk),
      .reset    (reset),
      .clr      (vec_clr_c),
      .inc      (vec_inc_c),
      .a        (vec_a),
      .b        (vec_b),
      .s        (vec_s),
      .idx      (vec_idx),
      .last_vec (last_vec)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.start) state_nxt = ST_SETTLE;
         ST_SETTLE: if (cnt_q == '0) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = last_vec ? ST_FIN : ST_SETTLE;
         ST_FIN:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Control strobes decoded from the current/next state
   always_comb begin
      vec_clr_c  = 1'b0;
      vec_inc_c  = 1'b0;
      cnt_load_c = 1'b0;
      check_c    = 1'b0;
      case (state)
         ST_IDLE:  vec_clr_c = bus.start;
         ST_CHECK: begin
            check_c   = 1'b1;
            vec_inc_c = !last_vec;
         end
         default: ;
      endcase
      if (state_nxt == ST_SETTLE && state != ST_SETTLE) cnt_load_c = 1'b1;
   end

   assign mismatch_c = (bus.ul_out != ul4_golden(vec_a, vec_b, vec_s));

   // Settle counter, verdict, error counter and first-failure capture
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_seen_q <= 1'b0;
         err_q       <= '0;
         fail_idx_q  <= '0;
      end else begin
         busy_q <= (state_nxt != ST_IDLE);
         done_q <= (state_nxt == ST_FIN);
         if (cnt_load_c) begin
            cnt_q <= SETTLE_LOAD;
         end else if (state == ST_SETTLE && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (vec_clr_c) begin
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            err_q       <= '0;
            fail_idx_q  <= '0;
         end else if (check_c) begin
            if (mismatch_c) begin
               if (err_q != ERR_MAX) err_q <= err_q + ERR_W'(1);
               if (!fail_seen_q) begin
                  fail_seen_q <= 1'b1;
                  fail_idx_q  <= vec_idx;
               end
            end
            if (last_vec) pass_q <= (err_q == '0) && !mismatch_c;
         end
      end
   end

   assign bus.a_o       = vec_a;
   assign bus.b_o       = vec_b;
   assign bus.s_o       = vec_s;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_seen = fail_seen_q;
   assign bus.fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_ul4_autotest.sv
// Bench for ul4_autotest: three instances (default, ERR_W=4, SETTLE_CYC=3),
// each fed by a behavioural ul4 with selectable faults.
module tb_ul4_autotest;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_r [3];
   int         fmode [3];
   logic [3:0] cmask [1024];
   int         n_asrt = 0;
   int         n_fail = 0;

   logic [3:0] a_obs [3];
   logic [3:0] b_obs [3];
   logic [1:0] s_obs [3];
   logic       done_obs [3];
   logic       busy_obs [3];
   logic       pass_obs [3];
   logic       fs_obs [3];
   logic [9:0] fidx_obs [3];
   logic [9:0] err_obs [3];

   always #5 clk = ~clk;

   ul4_autotest_if #(.ERR_W(10)) if0 ();
   ul4_autotest_if #(.ERR_W(4))  if1 ();
   ul4_autotest_if #(.ERR_W(10)) if2 ();

   ul4_autotest #(.SETTLE_CYC(1), .ERR_W(10)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   ul4_autotest #(.SETTLE_CYC(1), .ERR_W(4))  dut1 (.clk(clk), .reset(reset), .bus(if1));
   ul4_autotest #(.SETTLE_CYC(3), .ERR_W(10)) dut2 (.clk(clk), .reset(reset), .bus(if2));

   function automatic logic [3:0] ref_out(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s);
      case (s)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Unit under test: 0 correct, 1 stuck-at-0, 2 XOR returns AND, 3 masked corruption
   function automatic logic [3:0] fault_out(input int mode, input logic [3:0] a,
                                            input logic [3:0] b, input logic [1:0] s,
                                            input logic [3:0] m);
      case (mode)
         1:       return 4'h0;
         2:       return (s == 2'd2) ? (a & b) : ref_out(a, b, s);
         3:       return ref_out(a, b, s) ^ m;
         default: return ref_out(a, b, s);
      endcase
   endfunction

   assign if0.start = start_r[0];
   assign if1.start = start_r[1];
   assign if2.start = start_r[2];

   always_comb if0.ul_out = fault_out(fmode[0], if0.a_o, if0.b_o, if0.s_o, cmask[{if0.s_o, if0.b_o, if0.a_o}]);
   always_comb if1.ul_out = fault_out(fmode[1], if1.a_o, if1.b_o, if1.s_o, cmask[{if1.s_o, if1.b_o, if1.a_o}]);
   always_comb if2.ul_out = fault_out(fmode[2], if2.a_o, if2.b_o, if2.s_o, cmask[{if2.s_o, if2.b_o, if2.a_o}]);

   assign a_obs[0] = if0.a_o;  assign a_obs[1] = if1.a_o;  assign a_obs[2] = if2.a_o;
   assign b_obs[0] = if0.b_o;  assign b_obs[1] = if1.b_o;  assign b_obs[2] = if2.b_o;
   assign s_obs[0] = if0.s_o;  assign s_obs[1] = if1.s_o;  assign s_obs[2] = if2.s_o;
   assign done_obs[0] = if0.done;  assign done_obs[1] = if1.done;  assign done_obs[2] = if2.done;
   assign busy_obs[0] = if0.busy;  assign busy_obs[1] = if1.busy;  assign busy_obs[2] = if2.busy;
   assign pass_obs[0] = if0.pass;  assign pass_obs[1] = if1.pass;  assign pass_obs[2] = if2.pass;
   assign fs_obs[0] = if0.fail_seen;  assign fs_obs[1] = if1.fail_seen;  assign fs_obs[2] = if2.fail_seen;
   assign fidx_obs[0] = if0.fail_idx; assign fidx_obs[1] = if1.fail_idx; assign fidx_obs[2] = if2.fail_idx;
   assign err_obs[0] = if0.err_count;
   assign err_obs[1] = 10'(if1.err_count);
   assign err_obs[2] = if2.err_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int vec_of(input int k);
      return int'({s_obs[k], b_obs[k], a_obs[k]});
   endfunction

   // Reference: sweep all 1024 vectors through the faulty unit and the golden rules
   task automatic model_run(input int k, input int width, output int exp_err,
                            output int exp_idx, output bit exp_pass);
      int cnt = 0;
      int emax;
      exp_idx = 0;
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] v;
         v = 10'(i);
         if (fault_out(fmode[k], v[3:0], v[7:4], v[9:8], cmask[i]) !== ref_out(v[3:0], v[7:4], v[9:8])) begin
            if (cnt == 0) exp_idx = i;
            cnt++;
         end
      end
      emax     = (1 << width) - 1;
      exp_pass = (cnt == 0);
      exp_err  = (cnt > emax) ? emax : cnt;
   endtask

   task automatic check_reset_vals(input int k, input string tag);
      chk({tag, "_busy"}, 32'(busy_obs[k]), 0);
      chk({tag, "_done"}, 32'(done_obs[k]), 0);
      chk({tag, "_pass"}, 32'(pass_obs[k]), 0);
      chk({tag, "_fs"},   32'(fs_obs[k]), 0);
      chk({tag, "_err"},  32'(err_obs[k]), 0);
      chk({tag, "_fidx"}, 32'(fidx_obs[k]), 0);
      chk({tag, "_vec"},  32'(vec_of(k)), 0);
   endtask

   // Pulse start, wait for done within a bounded budget, check verdict and hold
   task automatic run_check(input int k, input int settle, input int width, input string tag);
      int  exp_err, exp_idx, cyc, lat;
      bit  exp_pass;
      model_run(k, width, exp_err, exp_idx, exp_pass);
      lat = 1 + 1024 * (settle + 1);
      @(negedge clk); start_r[k] = 1'b1;
      @(negedge clk); start_r[k] = 1'b0;
      cyc = 1;
      chk({tag, "_busy_on"}, 32'(busy_obs[k]), 1);
      chk({tag, "_vec0"}, 32'(vec_of(k)), 0);
      while (!done_obs[k] && cyc < lat + 50) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(lat));
      chk({tag, "_pass"}, 32'(pass_obs[k]), 32'(exp_pass));
      chk({tag, "_err"},  32'(err_obs[k]), 32'(exp_err));
      chk({tag, "_fs"},   32'(fs_obs[k]), 32'(!exp_pass));
      chk({tag, "_fidx"}, 32'(fidx_obs[k]), 32'(exp_idx));
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done_obs[k]), 0);
      chk({tag, "_idle"}, 32'(busy_obs[k]), 0);
      chk({tag, "_lastvec"}, 32'(vec_of(k)), 1023);
      chk({tag, "_err_hold"}, 32'(err_obs[k]), 32'(exp_err));
      chk({tag, "_pass_hold"}, 32'(pass_obs[k]), 32'(exp_pass));
   endtask

   initial begin
      int cyc, dones;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_r[k] = 1'b0;
         fmode[k]   = 0;
      end
      for (int i = 0; i < 1024; i++) cmask[i] = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_vals(0, "rst0");
      check_reset_vals(1, "rst1");
      check_reset_vals(2, "rst2");
      reset = 1'b0;
      @(negedge clk);

      run_check(0, 1, 10, "good");

      fmode[0] = 1;
      run_check(0, 1, 10, "stuck0");
      chk("stuck0_err_const", 32'(err_obs[0]), 910);
      chk("stuck0_fidx_const", 32'(fidx_obs[0]), 17);

      fmode[0] = 2;
      run_check(0, 1, 10, "xor_as_and");
      chk("xor_err_const", 32'(err_obs[0]), 255);
      chk("xor_fidx_const", 32'(fidx_obs[0]), 513);

      fmode[0] = 3;
      for (int j = 0; j < 6; j++) cmask[$urandom_range(1023, 0)] = 4'($urandom_range(15, 1));
      run_check(0, 1, 10, "rand_fault");
      for (int i = 0; i < 1024; i++) cmask[i] = 4'h0;

      // start held high: a new run starts in the IDLE cycle following FIN
      fmode[0] = 0;
      @(negedge clk); start_r[0] = 1'b1;
      cyc = 0;
      while (!done_obs[0] && cyc < 2100) begin
         @(negedge clk);
         cyc++;
      end
      chk("held_done_seen", 32'(done_obs[0]), 1);
      @(negedge clk);
      chk("held_idle_busy", 32'(busy_obs[0]), 0);
      chk("held_idle_vec", 32'(vec_of(0)), 1023);
      @(negedge clk);
      chk("held_restart_busy", 32'(busy_obs[0]), 1);
      chk("held_restart_vec", 32'(vec_of(0)), 0);
      chk("held_restart_pass_clr", 32'(pass_obs[0]), 0);
      start_r[0] = 1'b0;

      // start mid-run ignored; reset at cycle 500 aborts without done
      cyc = 1;
      dones = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (done_obs[0]) dones++;
      end
      start_r[0] = 1'b1;
      @(negedge clk); cyc++; start_r[0] = 1'b0;
      @(negedge clk); cyc++;
      chk("ignored_start_busy", 32'(busy_obs[0]), 1);
      chk("ignored_start_vec", 32'(vec_of(0)), 32'((cyc - 1) / 2));
      while (cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (done_obs[0]) dones++;
      end
      chk("no_done_before_reset", 32'(dones), 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals(0, "abort");
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done_obs[0]) dones++;
      end
      chk("no_done_after_abort", 32'(dones), 0);
      run_check(0, 1, 10, "post_abort");

      fmode[1] = 1;
      run_check(1, 1, 4, "sat");
      chk("sat_err_const", 32'(err_obs[1]), 15);
      chk("sat_fidx_const", 32'(fidx_obs[1]), 17);

      run_check(2, 3, 10, "settle3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/ul4_autotest.md
Name: ul4_autotest

Overview:
Hardware self-test sequencer for the 4-bit logic unit (ul4).
- Drives every (a, b, s) combination into a ul4 instance through its output ports, and samples the unit's Out through ul_out.
- Compares each sample against an internal golden model and counts mismatches.
- Reports a pass/fail verdict with a start/done handshake, so the ul4 can be checked on-board without a simulator.
- Sits beside the ul4 under test, between it and board switches/LEDs.

Parameters:
SETTLE_CYC, 1, cycles each vector is held before ul_out is sampled (legal range 1..15)
ERR_W, 10, width of the mismatch counter; saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  run request; sampled only in IDLE
ul_out  input  4  Out of the ul4 under test
a_o  output  4  operand a driven to the ul4
b_o  output  4  operand b driven to the ul4
s_o  output  2  operation select driven to the ul4
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at the end of a run
pass  output  1  1 when err_count==0 at the end of a run; held until next start
err_count  output  ERR_W  mismatch count, saturating
fail_seen  output  1  at least one mismatch occurred this run
fail_idx  output  10  vector index of the first mismatch

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; a_o, b_o, s_o, fail_idx=0; busy, done, pass, fail_seen, err_count=0.
- Reset mid-run aborts the run immediately; no done pulse is produced; all outputs return to reset values.
- Golden model (shared constants): s=00 a&b; s=01 a|b; s=10 a^b; s=11 ~a.
- Vector index i, 10 bits: a_o=i[3:0], b_o=i[7:4], s_o=i[9:8]; runs 0..1023 in order.
- FSM states: IDLE, SETTLE, CHECK, FIN.
- IDLE:
  - start=1 sets i=0, clears err_count, fail_seen, fail_idx and pass, and moves to SETTLE.
  - a_o/b_o/s_o show vector 0 from the next cycle.
- SETTLE: holds the vector for SETTLE_CYC cycles using a 4-bit down-counter, then moves to CHECK.
- CHECK, one cycle: compare ul_out with the golden model of the currently driven a_o/b_o/s_o.
  - On mismatch: err_count+1 unless already saturated.
  - On the first mismatch only: fail_seen=1 and fail_idx=i.
  - If i==1023, go to FIN; otherwise i+1 and go to SETTLE.
- FIN, one cycle: done=1; pass=(err_count==0 and no mismatch on the final compare); then IDLE.
- busy=1 in SETTLE, CHECK and FIN.
- Latency: start sampled at edge t, done high in cycle t+1+1024*(SETTLE_CYC+1). For SETTLE_CYC=1 that is 2049 cycles.
- start while busy is ignored (no restart, no queueing).
- start held high continuously: a new run begins in the IDLE cycle that follows FIN.
- In IDLE, a_o/b_o/s_o hold the last driven vector, 1023 (a=F, b=F, s=11), after a run.
- err_count stays valid after done until the next start.

Decomposition:
- Package ul4_pkg holds:
  - op-select constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11;
  - function ul4_golden(a, b, s);
  - FSM state encoding.
- One natural sub-module: ul4_vecgen. It holds the 10-bit index counter and its a/b/s split, and exposes last_vec.
- The FSM, compare logic and error counter stay in ul4_autotest.

Test Plan:
- Correct ul4 model on ul_out, pulse start -> done at cycle 2049; pass=1, err_count=0, fail_seen=0.
- ul_out stuck at 4'b0000 -> err_count=910, fail_seen=1, fail_idx=17 (a=1, b=1, s=00), pass=0.
- Faulty ul4 that returns a&b for s=10 -> err_count=255, fail_idx=513 (a=1, b=0, s=10), pass=0.
- ERR_W=4 with ul_out stuck at 0 -> err_count saturates at 15, fail_idx still 17.
- Reset asserted at cycle 500 of a run, then start -> no done before the restart; second run completes 2049 cycles after the new start; a start pulse at cycle 100 of the run is ignored.
- SETTLE_CYC=3 with the correct model -> done at cycle 1+1024*4=4097; pass=1.
